instr_fetch: RTL and testbench
==============================

# instr_fetch

Sequencing instruction-fetch unit for the 8-bit multicycle processor. Reads one 32-bit instruction as four consecutive byte reads from the shared byte-wide memory and assembles them into the instruction register. Presents the opcode and register fields to the control FSM and datapath. Sits directly upstream of `control`: `control` raises `start` in its fetch state and consumes `op` once `done` pulses.

## Interface
- `DATA_W`, 8: memory data width in bits.
- `ADDR_W`, 8: memory address width in bits.
- `INSTR_W`, 32: instruction width; must be a multiple of `DATA_W` (`BYTES = INSTR_W/DATA_W` = 4).

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a fetch at `pc`; sampled only when not busy.
- `abort`  in  1  synchronous flush of an in-progress fetch.
- `pc`  in  ADDR_W  byte address of the instruction; sampled with `start`.
- `memdata`  in  DATA_W  read data, valid exactly one cycle after `adr`/`memread`.
- `adr`  out  ADDR_W  memory byte address (registered).
- `memread`  out  1  memory read strobe (registered).
- `busy`  out  1  fetch in progress.
- `done`  out  1  one-cycle pulse; `instr` holds the newly fetched word.
- `instr`  out  INSTR_W  instruction register.
- `op`  out  6  `instr` bits 31..26.
- `rs`, `rt`, `rd`  out  5 each  `instr` bits 25..21, 20..16, 15..11.
- `funct`  out  6  `instr` bits 5..0.
- `imm`  out  16  `instr` bits 15..0.
- `nextpc`  out  ADDR_W  `pc + BYTES` mod 2^ADDR_W, registered at start.

## Operation
- FSM states:
  - IDLE: no fetch in progress.
  - ISSUE: issues byte reads k = 0..BYTES-1, driven by a 2-bit issue counter.
  - DRAIN: captures the final byte.
  - DONE: commits the word and pulses `done`.
- IDLE or DONE with `start`=1 and `abort`=0: latch `pc` into `base`, latch `pc+BYTES` into `nextpc`, clear the capture counter, go to ISSUE.
- ISSUE: drive `adr = base + k` (mod 2^ADDR_W, wrap permitted) and `memread`=1. After k = BYTES-1, go to DRAIN.
- Capture: on each cycle following an issue, shift `memdata` into the shadow register, big-endian. Byte at `base` lands in bits 31..24; byte at `base+3` lands in bits 7..0.
- DRAIN: capture the last byte, then go to DONE.
- DONE: `instr` takes the shadow value at the DRAIN→DONE edge; `done`=1 for this cycle only. The next state is ISSUE if `start` is high, otherwise IDLE.
- `instr` and all field outputs change only on that commit edge. They stay stable during a fetch, so `control` may decode the previous instruction while the next fetch runs.
- `abort` in ISSUE or DRAIN: go to IDLE next cycle.
  - Shadow is discarded; `instr` is unchanged; no `done`.
  - `memread` is 0 from the next cycle.
- `abort` with `start` in the same cycle: `abort` wins; `start` is ignored.
- `start` while in ISSUE or DRAIN: ignored. It is not queued.
- Reset (any time, including mid-fetch): state IDLE.
  - Outputs `adr`, `nextpc`, `instr` = 0 (so `op`/`rs`/`rt`/`rd`/`funct`/`imm` = 0); `memread`, `busy`, `done` = 0.
  - Internal shadow, `base` and both counters = 0.

## Timing
- `start` accepted in cycle c. Cycles c+1..c+4: `memread`=1, `adr` = `base`, `base+1`, `base+2`, `base+3`.
- Bytes captured at the ends of cycles c+2..c+5.
- Cycle c+6: `done`=1 and new `instr`/`op` visible. Fetch latency is 6 cycles from `start` to `done`.
- `busy`=1 in cycles c+1..c+5; it is 0 in IDLE and DONE.
- Back-to-back: `start` held high in c+6 gives the next `memread` in c+7, i.e. one instruction every 6 cycles.
- `nextpc` is valid from c+1 and holds until the next accepted `start`.
- Address arithmetic is ADDR_W-bit unsigned, truncated. `pc = 8'hFE` reads FE, FF, 00, 01, and `nextpc = 8'h02`.

## Structure
- Shared package `cpu_pkg`:
  - fetch state enum (IDLE, ISSUE, DRAIN, DONE);
  - `BYTES`;
  - instruction field bit-position constants (OP, RS, RT, RD, FUNCT, IMM).
  - `control` and the datapath decode from the same field constants.
- One natural sub-module: `byte_assembler`, a shadow shift register with capture enable and clear, parameterized by `DATA_W` and `BYTES`.
- FSM, counters and address generation live in `instr_fetch`.

## Test plan
- Reset mid-ISSUE (after 2 reads) → next cycle all outputs 0 and state IDLE; a subsequent `start` at `pc=8'h10` fetches normally.
- Memory holds 8C 22 00 04 at 0x10; `start`, `pc=8'h10` → `adr` 10, 11, 12, 13 in c+1..c+4; at c+6 `done`=1, `instr`=32'h8C220004, `op`=6'h23, `rs`=1, `rt`=2, `imm`=16'h0004, `nextpc`=8'h14.
- `pc=8'hFE`, memory FE..01 = 12 34 56 78 → `adr` wraps FE, FF, 00, 01; `instr`=32'h12345678, `nextpc`=8'h02.
- `abort` at c+3 after a previous fetch left `instr`=32'hDEADBEEF → `memread`=0 from c+4, no `done`, `instr` stays 32'hDEADBEEF; `start`+`abort` together in IDLE → no fetch.
- `start` held high continuously from 0x00 over words 0x00 and 0x04 → `done` at c+6 and c+12; `instr` stable between commits; `start` pulses in ISSUE ignored.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared processor definitions: fetch FSM states, instruction geometry and
// the instruction field bit positions used by fetch, control and datapath.
package cpu_pkg;

    // Bytes per instruction word on the byte-wide memory.
    localparam int BYTES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fetch_state_t;

    // Instruction field positions (MSB/LSB inclusive).
    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_MSB   = 15;
    localparam int IMM_LSB   = 0;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch request / memory / decoded-field bundle between the fetch unit
// (slave) and the control FSM plus memory (master).
interface instr_fetch_if #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 32
);
    logic               start;
    logic               abort;
    logic [ADDR_W-1:0]  pc;
    logic [DATA_W-1:0]  memdata;
    logic [ADDR_W-1:0]  adr;
    logic               memread;
    logic               busy;
    logic               done;
    logic [INSTR_W-1:0] instr;
    logic [5:0]         op;
    logic [4:0]         rs;
    logic [4:0]         rt;
    logic [4:0]         rd;
    logic [5:0]         funct;
    logic [15:0]        imm;
    logic [ADDR_W-1:0]  nextpc;

    modport master (
        output start, abort, pc, memdata,
        input  adr, memread, busy, done, instr, op, rs, rt, rd, funct, imm, nextpc
    );

    modport slave (
        input  start, abort, pc, memdata,
        output adr, memread, busy, done, instr, op, rs, rt, rd, funct, imm, nextpc
    );
endinterface

// File: rtl/byte_assembler.sv
// Big-endian shadow shift register. It keeps the first BYTES-1 bytes of a
// word; the full word is presented combinationally together with the byte
// currently on i_data, so the owner can commit it on the final capture edge.
module byte_assembler #(
    parameter int DATA_W = 8,
    parameter int BYTES  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_clear,
    input  logic                    i_capture,
    input  logic [DATA_W-1:0]       i_data,
    output logic [DATA_W*BYTES-1:0] o_word
);
    localparam int SH_W = DATA_W * (BYTES - 1);

    logic [SH_W-1:0] r_shadow;

    // Shift captured bytes in from the bottom; oldest byte ends up on top.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow <= '0;
        end else if (i_clear) begin
            r_shadow <= '0;
        end else if (i_capture) begin
            r_shadow <= SH_W'({r_shadow, i_data});
        end
    end

    assign o_word = {r_shadow, i_data};

endmodule

// File: rtl/instr_fetch.sv
// Multicycle instruction fetch: issues BYTES byte reads at pc..pc+BYTES-1,
// assembles them big-endian and commits the word to the instruction register
// with a one-cycle done pulse. The instruction register only changes on that
// commit, so the previous instruction stays decodable during a fetch.
module instr_fetch #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 32
) (
    input  logic         clk,
    input  logic         reset,
    instr_fetch_if.slave bus
);
    import cpu_pkg::*;

    localparam int NBYTES = INSTR_W / DATA_W;

    fetch_state_t        r_state;
    fetch_state_t        w_state_nxt;
    logic [1:0]          r_issue_cnt;
    logic [1:0]          w_issue_cnt_nxt;
    logic [1:0]          r_cap_cnt;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W-1:0]   r_adr;
    logic [ADDR_W-1:0]   w_adr_nxt;
    logic [ADDR_W-1:0]   r_nextpc;
    logic                r_memread;
    logic                w_memread_nxt;
    logic [INSTR_W-1:0]  r_instr;
    logic [INSTR_W-1:0]  w_word;
    logic                w_accept;
    logic                w_cap_en;
    logic                w_commit;

    byte_assembler #(
        .DATA_W (DATA_W),
        .BYTES  (NBYTES)
    ) u_byte_assembler (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_accept),
        .i_capture (w_cap_en),
        .i_data    (bus.memdata),
        .o_word    (w_word)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, issue sequencing and registered memory-port values.
    // Captures lag issues by one cycle, so the ISSUE cycle with count 0 has
    // no data yet and DRAIN takes the last byte.
    always_comb begin
        w_state_nxt     = r_state;
        w_issue_cnt_nxt = r_issue_cnt;
        w_adr_nxt       = r_adr;
        w_memread_nxt   = 1'b0;
        w_accept        = 1'b0;
        w_cap_en        = 1'b0;
        w_commit        = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (bus.start && !bus.abort) begin
                    w_accept        = 1'b1;
                    w_state_nxt     = ISSUE;
                    w_issue_cnt_nxt = 2'd0;
                    w_adr_nxt       = bus.pc;
                    w_memread_nxt   = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ISSUE: begin
                w_cap_en = (r_issue_cnt != 2'd0);
                if (bus.abort) begin
                    w_state_nxt = IDLE;
                end else if (r_issue_cnt == 2'(NBYTES - 1)) begin
                    w_state_nxt = DRAIN;
                end else begin
                    w_issue_cnt_nxt = r_issue_cnt + 2'd1;
                    w_adr_nxt       = r_base + ADDR_W'(w_issue_cnt_nxt);
                    w_memread_nxt   = 1'b1;
                end
            end
            DRAIN: begin
                w_cap_en = 1'b1;
                if (bus.abort) begin
                    w_state_nxt = IDLE;
                end else if (r_cap_cnt == 2'(NBYTES - 1)) begin
                    w_commit    = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Fetch bookkeeping: base/nextpc latch, counters, memory port, commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_issue_cnt <= 2'd0;
            r_cap_cnt   <= 2'd0;
            r_base      <= '0;
            r_nextpc    <= '0;
            r_adr       <= '0;
            r_memread   <= 1'b0;
            r_instr     <= '0;
        end else begin
            r_issue_cnt <= w_issue_cnt_nxt;
            r_adr       <= w_adr_nxt;
            r_memread   <= w_memread_nxt;
            if (w_accept) begin
                r_base    <= bus.pc;
                r_nextpc  <= bus.pc + ADDR_W'(NBYTES);
                r_cap_cnt <= 2'd0;
            end else if (w_cap_en) begin
                r_cap_cnt <= r_cap_cnt + 2'd1;
            end
            if (w_commit) begin
                r_instr <= w_word;
            end
        end
    end

    assign bus.adr     = r_adr;
    assign bus.memread = r_memread;
    assign bus.busy    = (r_state == ISSUE) || (r_state == DRAIN);
    assign bus.done    = (r_state == DONE);
    assign bus.instr   = r_instr;
    assign bus.nextpc  = r_nextpc;
    assign bus.op      = r_instr[OP_MSB:OP_LSB];
    assign bus.rs      = r_instr[RS_MSB:RS_LSB];
    assign bus.rt      = r_instr[RT_MSB:RT_LSB];
    assign bus.rd      = r_instr[RD_MSB:RD_LSB];
    assign bus.funct   = r_instr[FUNCT_MSB:FUNCT_LSB];
    assign bus.imm     = r_instr[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: byte memory model with one-cycle read latency, and a
// reference that expects each fetch to return the four bytes at pc..pc+3
// (8-bit wrap) concatenated big-endian, on a fixed six-cycle schedule.
module tb_instr_fetch;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [7:0]  mem [0:255];
    logic [31:0] exp_instr;

    instr_fetch_if #(.DATA_W(8), .ADDR_W(8), .INSTR_W(32)) bus ();

    instr_fetch #(.DATA_W(8), .ADDR_W(8), .INSTR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory: data for a read strobed in one cycle appears in the next;
    // junk on the bus otherwise.
    always @(posedge clk) begin
        if (bus.memread) bus.memdata <= mem[bus.adr];
        else             bus.memdata <= 8'($urandom);
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One fetch from an accepting state; checks every cycle c+1..c+6.
    // With hold, start stays high and pc is scrambled mid-fetch.
    task automatic fetch_chk(input logic [7:0] pc, input bit hold);
        logic [7:0]  a1, a2, a3, ea;
        logic [31:0] w;
        bit          e_rd, e_busy, e_done;
        logic [31:0] e_instr;
        a1 = pc + 8'd1;
        a2 = pc + 8'd2;
        a3 = pc + 8'd3;
        w  = {mem[pc], mem[a1], mem[a2], mem[a3]};
        bus.pc    = pc;
        bus.start = 1'b1;
        bus.abort = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) begin
                if (hold) bus.pc = 8'($urandom);
                else      bus.start = 1'b0;
            end
            ea      = pc + 8'(k - 1);
            e_rd    = (k <= 4);
            e_busy  = (k <= 5);
            e_done  = (k == 6);
            e_instr = (k == 6) ? w : exp_instr;
            checks++;
            if (bus.memread !== e_rd) begin
                errors++;
                $display("FAIL fetch_memread pc=%h k=%0d got %b exp %b", pc, k, bus.memread, e_rd);
            end
            if (k <= 4) begin
                checks++;
                if (bus.adr !== ea) begin
                    errors++;
                    $display("FAIL fetch_adr pc=%h k=%0d got %h exp %h", pc, k, bus.adr, ea);
                end
            end
            checks++;
            if (bus.busy !== e_busy) begin
                errors++;
                $display("FAIL fetch_busy pc=%h k=%0d got %b exp %b", pc, k, bus.busy, e_busy);
            end
            checks++;
            if (bus.done !== e_done) begin
                errors++;
                $display("FAIL fetch_done pc=%h k=%0d got %b exp %b", pc, k, bus.done, e_done);
            end
            checks++;
            if (bus.instr !== e_instr) begin
                errors++;
                $display("FAIL fetch_instr pc=%h k=%0d got %h exp %h", pc, k, bus.instr, e_instr);
            end
            checks++;
            if (bus.nextpc !== 8'(pc + 8'd4)) begin
                errors++;
                $display("FAIL fetch_nextpc pc=%h k=%0d got %h exp %h", pc, k, bus.nextpc, 8'(pc + 8'd4));
            end
        end
        exp_instr = w;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++;
        if ({bus.adr, bus.memread, bus.busy, bus.done} !== 11'd0) begin
            errors++;
            $display("FAIL reset_ctrl got adr=%h rd=%b busy=%b done=%b exp all 0", bus.adr, bus.memread, bus.busy, bus.done);
        end
        checks++;
        if (bus.instr !== 32'd0) begin
            errors++;
            $display("FAIL reset_instr got %h exp 0", bus.instr);
        end
        checks++;
        if ({bus.op, bus.rs, bus.rt, bus.rd, bus.funct, bus.imm} !== 43'd0) begin
            errors++;
            $display("FAIL reset_fields got op=%h rs=%h rt=%h rd=%h funct=%h imm=%h exp 0", bus.op, bus.rs, bus.rt, bus.rd, bus.funct, bus.imm);
        end
        checks++;
        if (bus.nextpc !== 8'd0) begin
            errors++;
            $display("FAIL reset_nextpc got %h exp 0", bus.nextpc);
        end
        reset = 1'b0;
        exp_instr = 32'd0;
        repeat (2) tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.memread !== 1'b0) begin
            errors++;
            $display("FAIL idle_nostart got busy=%b rd=%b exp 0 0", bus.busy, bus.memread);
        end
    endtask

    task automatic test_basic();
        mem[8'h10] = 8'h8C; mem[8'h11] = 8'h22; mem[8'h12] = 8'h00; mem[8'h13] = 8'h04;
        fetch_chk(8'h10, 1'b0);
        checks++;
        if (bus.instr !== 32'h8C220004) begin
            errors++;
            $display("FAIL basic_instr got %h exp 8c220004", bus.instr);
        end
        checks++;
        if (bus.op !== 6'h23 || bus.rs !== 5'd1 || bus.rt !== 5'd2) begin
            errors++;
            $display("FAIL basic_op_rs_rt got %h %h %h exp 23 01 02", bus.op, bus.rs, bus.rt);
        end
        checks++;
        if (bus.rd !== 5'd0 || bus.funct !== 6'h04 || bus.imm !== 16'h0004) begin
            errors++;
            $display("FAIL basic_rd_funct_imm got %h %h %h exp 00 04 0004", bus.rd, bus.funct, bus.imm);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.instr !== 32'h8C220004) begin
            errors++;
            $display("FAIL basic_after got done=%b busy=%b instr=%h exp 0 0 8c220004", bus.done, bus.busy, bus.instr);
        end
    endtask

    task automatic test_reset_mid();
        bus.pc = 8'h10;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        checks++;
        if (bus.memread !== 1'b1 || bus.adr !== 8'h11) begin
            errors++;
            $display("FAIL midreset_pre got rd=%b adr=%h exp 1 11", bus.memread, bus.adr);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({bus.adr, bus.memread, bus.busy, bus.done, bus.nextpc} !== 19'd0) begin
            errors++;
            $display("FAIL midreset_ctrl got adr=%h rd=%b busy=%b done=%b npc=%h exp 0", bus.adr, bus.memread, bus.busy, bus.done, bus.nextpc);
        end
        checks++;
        if (bus.instr !== 32'd0 || bus.op !== 6'd0) begin
            errors++;
            $display("FAIL midreset_instr got %h op %h exp 0", bus.instr, bus.op);
        end
        reset = 1'b0;
        exp_instr = 32'd0;
        tick();
        fetch_chk(8'h10, 1'b0);
    endtask

    task automatic test_wrap();
        mem[8'hFE] = 8'h12; mem[8'hFF] = 8'h34; mem[8'h00] = 8'h56; mem[8'h01] = 8'h78;
        tick();
        fetch_chk(8'hFE, 1'b0);
        checks++;
        if (bus.instr !== 32'h12345678 || bus.nextpc !== 8'h02) begin
            errors++;
            $display("FAIL wrap got instr=%h npc=%h exp 12345678 02", bus.instr, bus.nextpc);
        end
    endtask

    task automatic test_abort();
        mem[8'h40] = 8'hDE; mem[8'h41] = 8'hAD; mem[8'h42] = 8'hBE; mem[8'h43] = 8'hEF;
        fetch_chk(8'h40, 1'b0);
        tick();
        bus.pc = 8'h50;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (2) tick();
        checks++;
        if (bus.memread !== 1'b1 || bus.adr !== 8'h52) begin
            errors++;
            $display("FAIL abort_pre got rd=%b adr=%h exp 1 52", bus.memread, bus.adr);
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        checks++;
        if (bus.memread !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_stop got rd=%b busy=%b exp 0 0", bus.memread, bus.busy);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (bus.done !== 1'b0 || bus.memread !== 1'b0 || bus.instr !== 32'hDEADBEEF) begin
                errors++;
                $display("FAIL abort_hold i=%0d got done=%b rd=%b instr=%h exp 0 0 deadbeef", i, bus.done, bus.memread, bus.instr);
            end
        end
        bus.pc = 8'h10;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.busy !== 1'b0 || bus.memread !== 1'b0 || bus.done !== 1'b0 || bus.instr !== 32'hDEADBEEF) begin
                errors++;
                $display("FAIL start_abort i=%0d got busy=%b rd=%b done=%b instr=%h exp 0 0 0 deadbeef", i, bus.busy, bus.memread, bus.done, bus.instr);
            end
            tick();
        end
        fetch_chk(8'h40, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
        tick();
        fetch_chk(8'h00, 1'b1);
        fetch_chk(8'h04, 1'b0);
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end got busy=%b done=%b exp 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_random();
        logic [7:0] pc;
        bit         hold;
        int         gap;
        for (int n = 0; n < 40; n++) begin
            pc   = 8'($urandom);
            hold = 1'($urandom);
            fetch_chk(pc, hold);
            if (!hold) begin
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    tick();
                    checks++;
                    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.instr !== exp_instr) begin
                        errors++;
                        $display("FAIL rand_gap n=%0d got busy=%b done=%b instr=%h exp 0 0 %h", n, bus.busy, bus.done, bus.instr, exp_instr);
                    end
                end
            end
        end
        bus.start = 1'b0;
        tick();
    endtask

    initial begin
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.pc      = 8'h00;
        bus.memdata = 8'h00;
        exp_instr   = 32'd0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        test_reset();
        test_basic();
        test_reset_mid();
        test_wrap();
        test_abort();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
